vga_timing_gen: RTL and testbench

- Parametrised raster timing generator; successor to the fixed 1280x1024@60 sync block.
- Produces the following, all cycle-aligned, for any VESA-style mode:
  - hsync/vsync with selectable polarity
  - display enable
  - pixel coordinates
  - frame/line/vblank strobes
- Sits between the pixel-clock domain and the framebuffer/pixel pipeline.
- A PIPE parameter delays every timing output equally, to match downstream memory read latency.

---
 rtl/vga_timing_gen.sv | 131 +++++++++++++
 tb/tb_vga_timing_gen.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VESA-style raster timing generator
// Counters feed one decode register, then PIPE equal-delay stages.
module vga_timing_gen #(
  parameter int CW       = 12,
  parameter int H_ACTIVE = 1280,
  parameter int H_FRONT  = 48,
  parameter int H_PULSE  = 112,
  parameter int H_BACK   = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FRONT  = 1,
  parameter int V_PULSE  = 3,
  parameter int V_BACK   = 38,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int PIPE     = 0
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          EN,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          de_out,
  output logic          vblank_out,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Boundaries carry one spare bit so a region ending exactly at 2^CW still compares correctly
  localparam logic [CW:0] H_ACT_END  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(H_ACTIVE + H_FRONT);
  localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_ACTIVE + H_FRONT + H_PULSE);
  localparam logic [CW:0] V_ACT_END  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(V_ACTIVE + V_FRONT);
  localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_ACTIVE + V_FRONT + V_PULSE);

  localparam logic HS_ACT  = (HS_POL != 0);
  localparam logic HS_IDLE = (HS_POL == 0);
  localparam logic VS_ACT  = (VS_POL != 0);
  localparam logic VS_IDLE = (VS_POL == 0);

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_width_check
    $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in CW bits");
  end

  if (PIPE < 0 || PIPE > 4) begin : g_pipe_check
    $error("vga_timing_gen: PIPE must be in 0..4");
  end

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic          vblank;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          ls;
    logic          fs;
  } timing_t;

  localparam timing_t IDLE = '{hs: HS_IDLE, vs: VS_IDLE, de: 1'b0, vblank: 1'b0,
                               x: '0, y: '0, ls: 1'b0, fs: 1'b0};

  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic          h_act, v_act, hs, vs, de;
  timing_t       dec_d;
  timing_t       pipe_q [PIPE+1];

  always_comb begin
    hcnt_d = hcnt_q + CNT_ONE;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_ONE;
    end
  end

  always_comb begin
    h_act = {1'b0, hcnt_q} < H_ACT_END;
    v_act = {1'b0, vcnt_q} < V_ACT_END;
    hs    = ({1'b0, hcnt_q} >= H_SYNC_BEG) && ({1'b0, hcnt_q} < H_SYNC_END);
    vs    = ({1'b0, vcnt_q} >= V_SYNC_BEG) && ({1'b0, vcnt_q} < V_SYNC_END);
    de    = h_act && v_act;

    dec_d        = IDLE;
    dec_d.hs     = hs ? HS_ACT : HS_IDLE;
    dec_d.vs     = vs ? VS_ACT : VS_IDLE;
    dec_d.de     = de;
    dec_d.vblank = !v_act;
    dec_d.x      = de ? hcnt_q : '0;
    dec_d.y      = de ? vcnt_q : '0;
    dec_d.ls     = (hcnt_q == '0);
    dec_d.fs     = (hcnt_q == '0) && (vcnt_q == '0);
  end

  // EN low idles only the first stage; later stages keep shifting so they drain
  always_ff @(posedge CLK) begin
    if (RESET || !EN) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      pipe_q[0] <= IDLE;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      pipe_q[0] <= dec_d;
    end
    for (int i = 1; i <= PIPE; i++) begin
      pipe_q[i] <= RESET ? IDLE : pipe_q[i-1];
    end
  end

  assign hsync_out   = pipe_q[PIPE].hs;
  assign vsync_out   = pipe_q[PIPE].vs;
  assign de_out      = pipe_q[PIPE].de;
  assign vblank_out  = pipe_q[PIPE].vblank;
  assign pix_x       = pipe_q[PIPE].x;
  assign pix_y       = pipe_q[PIPE].y;
  assign line_start  = pipe_q[PIPE].ls;
  assign frame_start = pipe_q[PIPE].fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
// Four instances: small mode (pol 1 / pol 0 / PIPE 3) and default horizontal timing.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst = 4'hf;
  logic [3:0] en  = 4'hf;

  logic [3:0] hs, vs, de, vb, ls, fs;
  logic [3:0] px_a, py_a, px_b, py_b, px_c, py_c;
  logic [11:0] px_d, py_d;
  logic [11:0] px [4];
  logic [11:0] py [4];

  assign px[0] = {8'h0, px_a};
  assign py[0] = {8'h0, py_a};
  assign px[1] = {8'h0, px_b};
  assign py[1] = {8'h0, py_b};
  assign px[2] = {8'h0, px_c};
  assign py[2] = {8'h0, py_c};
  assign px[3] = px_d;
  assign py[3] = py_d;

  vga_timing_gen #(.CW(4), .H_ACTIVE(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(3),
                   .V_ACTIVE(4), .V_FRONT(1), .V_PULSE(2), .V_BACK(1),
                   .HS_POL(1), .VS_POL(1), .PIPE(0)) u_a (
    .CLK(clk), .RESET(rst[0]), .EN(en[0]), .hsync_out(hs[0]), .vsync_out(vs[0]),
    .de_out(de[0]), .vblank_out(vb[0]), .pix_x(px_a), .pix_y(py_a),
    .line_start(ls[0]), .frame_start(fs[0]));

  vga_timing_gen #(.CW(4), .H_ACTIVE(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(3),
                   .V_ACTIVE(4), .V_FRONT(1), .V_PULSE(2), .V_BACK(1),
                   .HS_POL(0), .VS_POL(0), .PIPE(0)) u_b (
    .CLK(clk), .RESET(rst[1]), .EN(en[1]), .hsync_out(hs[1]), .vsync_out(vs[1]),
    .de_out(de[1]), .vblank_out(vb[1]), .pix_x(px_b), .pix_y(py_b),
    .line_start(ls[1]), .frame_start(fs[1]));

  vga_timing_gen #(.CW(4), .H_ACTIVE(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(3),
                   .V_ACTIVE(4), .V_FRONT(1), .V_PULSE(2), .V_BACK(1),
                   .HS_POL(1), .VS_POL(1), .PIPE(3)) u_c (
    .CLK(clk), .RESET(rst[2]), .EN(en[2]), .hsync_out(hs[2]), .vsync_out(vs[2]),
    .de_out(de[2]), .vblank_out(vb[2]), .pix_x(px_c), .pix_y(py_c),
    .line_start(ls[2]), .frame_start(fs[2]));

  vga_timing_gen #(.CW(12), .V_ACTIVE(4), .PIPE(0)) u_d (
    .CLK(clk), .RESET(rst[3]), .EN(en[3]), .hsync_out(hs[3]), .vsync_out(vs[3]),
    .de_out(de[3]), .vblank_out(vb[3]), .pix_x(px_d), .pix_y(py_d),
    .line_start(ls[3]), .frame_start(fs[3]));

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        vb;
    logic [11:0] x;
    logic [11:0] y;
    logic        ls;
    logic        fs;
  } exp_t;

  int cfg_ht[4]   = '{16, 16, 16, 1688};
  int cfg_vt[4]   = '{8, 8, 8, 46};
  int cfg_ha[4]   = '{8, 8, 8, 1280};
  int cfg_hf[4]   = '{2, 2, 2, 48};
  int cfg_hp[4]   = '{3, 3, 3, 112};
  int cfg_va[4]   = '{4, 4, 4, 4};
  int cfg_vf[4]   = '{1, 1, 1, 1};
  int cfg_vp[4]   = '{2, 2, 2, 3};
  int cfg_hpol[4] = '{1, 0, 1, 1};
  int cfg_vpol[4] = '{1, 0, 1, 1};
  int cfg_pipe[4] = '{0, 0, 3, 0};

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  function automatic exp_t idle_val(int k);
    exp_t e = '0;
    e.hs = (cfg_hpol[k] == 0);
    e.vs = (cfg_vpol[k] == 0);
    return e;
  endfunction

  // Expected decode for frame position p (clocks since frame start)
  function automatic exp_t decode(int k, int p);
    exp_t e = '0;
    int h = p % cfg_ht[k];
    int v = p / cfg_ht[k];
    bit hsa = (h >= cfg_ha[k] + cfg_hf[k]) && (h < cfg_ha[k] + cfg_hf[k] + cfg_hp[k]);
    bit vsa = (v >= cfg_va[k] + cfg_vf[k]) && (v < cfg_va[k] + cfg_vf[k] + cfg_vp[k]);
    e.hs = hsa ? (cfg_hpol[k] != 0) : (cfg_hpol[k] == 0);
    e.vs = vsa ? (cfg_vpol[k] != 0) : (cfg_vpol[k] == 0);
    e.de = (h < cfg_ha[k]) && (v < cfg_va[k]);
    e.vb = (v >= cfg_va[k]);
    e.x  = e.de ? 12'(h) : 12'd0;
    e.y  = e.de ? 12'(v) : 12'd0;
    e.ls = (h == 0);
    e.fs = (p == 0);
    return e;
  endfunction

  function automatic exp_t actual(int k);
    return {hs[k], vs[k], de[k], vb[k], px[k], py[k], ls[k], fs[k]};
  endfunction

  int         mpos [4]     = '{default: 0};
  exp_t [4:0] hist_s0 [4]  = '{default: '0};
  logic [4:0] hist_rst [4] = '{default: 5'h1f};
  exp_t       exp_q [4];

  // Output = first-stage value PIPE clocks ago, unless RESET hit any stage on the way
  always @(posedge clk) begin
    exp_t s0;
    exp_t [4:0] h;
    logic [4:0] r;
    logic [4:0] m;
    for (int k = 0; k < 4; k++) begin
      s0 = (rst[k] || !en[k]) ? idle_val(k) : decode(k, mpos[k]);
      h  = {hist_s0[k][3:0], s0};
      r  = {hist_rst[k][3:0], rst[k]};
      m  = 5'((1 << (cfg_pipe[k] + 1)) - 1);
      hist_s0[k]  <= h;
      hist_rst[k] <= r;
      mpos[k]     <= (rst[k] || !en[k]) ? 0 : (mpos[k] + 1) % (cfg_ht[k] * cfg_vt[k]);
      exp_q[k]    <= ((r & m) != 5'd0) ? idle_val(k) : h[cfg_pipe[k]];
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (actual(k) !== exp_q[k]) begin
          failures++;
          $display("FAIL model inst=%0d t=%0t actual=%h required=%h", k, $time, actual(k), exp_q[k]);
        end
      end
    end
  end

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic run_a();
    int   first_fs[3] = '{0, 0, 0};
    int   fs_cyc[2]   = '{0, 0};
    int   fs_cnt = 0, de_cnt = 0, ls_cnt = 0, last_ls = 0;
    int   vlow = 0, vedge = 0, vmis = 0, shmis = 0, maxx = 0, maxy = 0, stray = 0;
    int   glitch = 0, w = 0, fs_c2 = 0;
    logic [31:0] hmask = '0;
    logic prev_vs;
    exp_t ha [301];

    // Normal running: all three small-mode instances released together
    prev_vs = vs[1];
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      ha[c] = actual(0);
      for (int k = 0; k < 3; k++) if (fs[k] && first_fs[k] == 0) first_fs[k] = c;
      if (fs[0]) begin
        if (fs_cnt < 2) fs_cyc[fs_cnt] = c;
        fs_cnt++;
      end
      if (fs_cnt == 1) begin
        if (de[0]) de_cnt++;
        if (ls[0]) begin
          ls_cnt++;
          last_ls = c;
        end
        if (hs[0] && (c - last_ls) < 32) hmask[c - last_ls] = 1'b1;
        if (!vs[1]) vlow++;
        if (vs[1] != prev_vs) begin
          vedge++;
          if (!ls[1]) vmis++;
        end
      end
      prev_vs = vs[1];
      if (c > 3 && actual(2) !== ha[c-3]) shmis++;
      if (de[2]) begin
        if (int'(px[2]) > maxx) maxx = int'(px[2]);
        if (int'(py[2]) > maxy) maxy = int'(py[2]);
      end else if (px[2] != 0 || py[2] != 0) begin
        stray++;
      end
    end
    chk("first_fs_pipe0", first_fs[0], 1);
    chk("first_fs_pipe3", first_fs[2], 4);
    chk("fs_period", fs_cyc[1] - fs_cyc[0], 128);
    chk("de_per_frame", de_cnt, 32);
    chk("ls_per_frame", ls_cnt, 8);
    chk("hs_offsets_mask", int'(hmask), 32'h1c00);
    chk("vs_low_clocks", vlow, 32);
    chk("vs_edges", vedge, 2);
    chk("vs_edge_align", vmis, 0);
    chk("pipe3_shift", shmis, 0);
    chk("pix_x_max", maxx, 7);
    chk("pix_y_max", maxy, 3);
    chk("pix_stray", stray, 0);

    // RESET for one clock with the counters at hcnt=5, vcnt=2
    while (mpos[0] != 37 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("reach_h5_v2", mpos[0], 37);
    rst[0] = 1'b1;
    rst[2] = 1'b1;
    @(negedge clk);
    chk("rst_idle_a", int'(actual(0)), 0);
    chk("rst_idle_c", int'(actual(2)), 0);
    rst[0] = 1'b0;
    rst[2] = 1'b0;
    first_fs = '{0, 0, 0};
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k += 2) if (fs[k] && first_fs[k] == 0) first_fs[k] = c;
      if (first_fs[2] == 0 && (de[2] || vs[2])) glitch++;
    end
    chk("rst_first_fs_pipe0", first_fs[0], 1);
    chk("rst_first_fs_pipe3", first_fs[2], 4);
    chk("rst_no_glitch", glitch, 0);

    // EN low for 20 clocks, dropped mid-line
    w = 0;
    while ((mpos[0] < 16 || mpos[0] % 16 != 4) && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("reach_mid_line", mpos[0] % 16, 4);
    en[0] = 1'b0;
    en[2] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("en_idle_pipe0", int'(actual(0)), 0);
        chk("en_drain_pipe3_de", de[2], 1);
      end
      if (c == 4) chk("en_idle_pipe3", int'(actual(2)), 0);
    end
    en[0] = 1'b1;
    en[2] = 1'b1;
    first_fs = '{0, 0, 0};
    fs_cnt = 0;
    de_cnt = 0;
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk);
      if (fs[0] && first_fs[0] == 0) first_fs[0] = c;
      else if (fs[0] && fs_cnt == 0) fs_cnt = c;
      if (fs[2] && first_fs[2] == 0) first_fs[2] = c;
      else if (fs[2] && fs_c2 == 0) fs_c2 = c;
      if (first_fs[0] != 0 && fs_cnt == 0 && de[0]) de_cnt++;
    end
    chk("en_first_fs_pipe0", first_fs[0], 1);
    chk("en_first_fs_pipe3", first_fs[2], 4);
    chk("en_frame_period_pipe0", fs_cnt - first_fs[0], 128);
    chk("en_frame_period_pipe3", fs_c2 - first_fs[2], 128);
    chk("en_frame_de", de_cnt, 32);
  endtask

  task automatic run_d();
    int fsn = 0, fs1 = 0, fs2 = 0, hr1 = 0, hr2 = 0;
    int vb_lines = 0, vs_clk = 0, de_cnt = 0, lx = 0, ly = 0;
    logic ph;
    ph = hs[3];
    for (int c = 1; c <= 80000 && fsn < 2; c++) begin
      @(negedge clk);
      if (fs[3]) begin
        fsn++;
        if (fsn == 1) fs1 = c;
        else fs2 = c;
      end
      if (hs[3] && !ph) begin
        if (hr1 == 0) hr1 = c;
        else if (hr2 == 0) hr2 = c;
      end
      ph = hs[3];
      if (fsn == 1) begin
        if (ls[3] && vb[3]) vb_lines++;
        if (vs[3]) vs_clk++;
        if (de[3]) begin
          de_cnt++;
          lx = int'(px[3]);
          ly = int'(py[3]);
        end
      end
    end
    chk("d_frames_seen", fsn, 2);
    chk("d_hsync_period", hr2 - hr1, 1688);
    chk("d_frame_period", fs2 - fs1, 1688 * 46);
    chk("d_vblank_lines", vb_lines, 42);
    chk("d_vsync_clocks", vs_clk, 3 * 1688);
    chk("d_de_clocks", de_cnt, 1280 * 4);
    chk("d_last_pix_x", lx, 1279);
    chk("d_last_pix_y", ly, 3);
  endtask

  initial begin
    exp_t e;
    repeat (6) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_hs_pol1", hs[0], 0);
    chk("rst_hs_pol0", hs[1], 1);
    chk("rst_vs_pol0", vs[1], 1);
    chk("rst_de_pipe3", de[2], 0);
    chk("rst_vb", vb[3], 0);
    chk("rst_fs", fs[0], 0);

    e = decode(3, 3 * 1688 + 1279);
    chk("model_last_pix_x", int'(e.x), 1279);
    chk("model_last_pix_y", int'(e.y), 3);
    e = decode(0, 5 * 16 + 11);
    chk("model_hs_v5_h11", e.hs, 1);
    chk("model_vs_v5_h11", e.vs, 1);
    chk("model_de_v5_h11", e.de, 0);

    rst = 4'h0;
    fork
      run_a();
      run_d();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
